fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_skid.sv | 33 +++
 rtl/fetch_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: reset defaults,
// FSM encoding and the fetched-entry record carried by the skid buffer.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction that arrived while the
// IF/ID register was stalled.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output logic         full,
  output fetch_entry_t entry
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  // NOTE: the payload is deliberately left out of reset; it is only ever read
  // while full is set, so resetting it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (load) begin
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM, redirect handling,
// stall skid buffer and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_sel,
  input  logic [31:0] target_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  fun3,
  output logic        fun7
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;

  logic         resp_kept;
  logic         accept;
  logic         capture;
  logic         issue_idle;
  logic         skid_full;
  logic         skid_load;
  logic         skid_clear;
  fetch_entry_t skid_entry;
  fetch_entry_t resp_entry;

  assign pc_plus4 = pc + PC_STEP;

  // A redirect outranks both stall and any response arriving in the same cycle.
  always_comb begin
    resp_kept  = (state == ST_WAIT) && imem_valid;
    accept     = resp_kept && !stall && !skid_full && !next_sel;
    capture    = resp_kept && stall && !next_sel;
    issue_idle = (state == ST_IDLE) && !skid_full && !next_sel;
    imem_req   = rst && (issue_idle || accept);
    imem_addr  = accept ? pc_plus4 : pc;
    skid_load  = capture;
    skid_clear = next_sel || (!stall && skid_full);
    resp_entry = '{pc: pc, instr: imem_rdata};
  end

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_entry(resp_entry),
    .full      (skid_full),
    .entry     (skid_entry)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else if (next_sel) begin
      pc    <= word_align(target_pc);
      // An in-flight request that has not returned must be swallowed later.
      state <= (state != ST_IDLE && !imem_valid) ? ST_DROP : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_idle) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (accept) begin
            pc <= pc_plus4;
          end else if (capture) begin
            pc    <= pc_plus4;
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (imem_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0000_0000;
      if_instr <= NOP_INSTR;
    end else if (next_sel) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (accept) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_rdata;
      end else if (skid_full) begin
        if_valid <= 1'b1;
        if_pc    <= skid_entry.pc;
        if_instr <= skid_entry.instr;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

  assign if_pc_plus4 = if_pc + PC_STEP;
  assign opcode      = if_instr[6:0];
  assign fun3        = if_instr[14:12];
  assign fun7        = if_instr[30];

endmodule
